// File: rtl/note_detector_pkg.sv
// Shared constants, FSM state type and period classifier for the note detector.
// Latency: n/a (package only).
// Backpressure: n/a.
package note_detector_pkg;

  localparam int              PERIOD_W   = 13;
  localparam int              NUM_NOTES  = 12;
  localparam logic [3:0]      NOTE_NONE  = 4'hF;
  localparam logic [PERIOD_W-1:0] GLITCH_MIN = 13'd1000;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_e;

  // Upper period bound (inclusive) of note k; entry k+1 is the exclusive lower bound.
  function automatic logic [PERIOD_W-1:0] thresh(input int k);
    logic [PERIOD_W-1:0] t;
    case (k)
      0:       t = 13'd3934;
      1:       t = 13'd3714;
      2:       t = 13'd3505;
      3:       t = 13'd3308;
      4:       t = 13'd3123;
      5:       t = 13'd2947;
      6:       t = 13'd2782;
      7:       t = 13'd2626;
      8:       t = 13'd2479;
      9:       t = 13'd2340;
      10:      t = 13'd2208;
      11:      t = 13'd2084;
      12:      t = 13'd1967;
      default: t = '0;
    endcase
    return t;
  endfunction

  // Map a measured period to a semitone index; anything outside the octave is NOTE_NONE.
  function automatic logic [3:0] classify(input logic [PERIOD_W-1:0] p);
    logic [3:0] c;
    c = NOTE_NONE;
    for (int k = 0; k < NUM_NOTES; k++) begin
      if ((p <= thresh(k)) && (p > thresh(k + 1))) c = 4'(k);
    end
    return c;
  endfunction

endpackage

// File: rtl/note_detector_sig_sync_edge.sv
// Two-flop synchroniser for the comparator input plus a registered rising-edge pulse.
// Latency: rise_pls is high 3 clk edges after sig_in rises, for exactly one cycle.
// Backpressure: none; every synchronised 0->1 transition produces a pulse.
module sig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise_pls
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic sync_dly_q, sync_dly_d;
  logic rise_q, rise_d;

  // Next-state: shift the input through the synchroniser and flag a 0->1 step.
  always_comb begin
    meta_d     = sig_in;
    sync_d     = meta_q;
    sync_dly_d = sync_q;
    rise_d     = sync_q & ~sync_dly_q;
  end

  // State registers, all cleared by reset so a low input produces no pulse afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      rise_q     <= rise_d;
    end
  end

  assign rise_pls = rise_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square wave, classifies it to a semitone, debounces over STABLE_COUNT periods.
// Latency: note/note_valid update 2 cycles after the internal edge pulse (5 clk edges after sig_in rises).
// Backpressure: none. Optional macro NOTE_DETECTOR_GLITCH_FILTER_EN ignores edges < GLITCH_MIN cycles apart.
module note_detector
  import note_detector_pkg::*;
#(
  parameter int STABLE_COUNT = 3,
  parameter int TIMEOUT      = 8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [3:0] note,
  output logic       note_valid
);

  localparam int                  MATCH_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [MATCH_W-1:0]  STABLE_C  = MATCH_W'(STABLE_COUNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

  logic                rise_pls;
  logic                accept;
  logic [3:0]          cls;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                per_vld_q, per_vld_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [3:0]          prev_cls_q, prev_cls_d;
  logic [3:0]          note_q, note_d;
  logic                note_valid_q, note_valid_d;

  sig_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .rise_pls (rise_pls)
  );

  // Period FSM, classifier stage and debounce; edge acceptance beats timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_d        = per_q;
    per_vld_d    = 1'b0;
    match_d      = match_q;
    prev_cls_d   = prev_cls_q;
    note_d       = note_q;
    note_valid_d = 1'b0;

    accept = rise_pls;
`ifdef NOTE_DETECTOR_GLITCH_FILTER_EN
    if ((state_q == ST_MEASURE) && (cnt_q < GLITCH_MIN)) accept = 1'b0;
`endif

    // Stage 2: classify the period latched on the previous cycle.
    cls = classify(per_q);
    if (per_vld_q) begin
      if (cls == prev_cls_q) begin
        if (match_q < STABLE_C) match_d = match_q + 1'b1;
      end else begin
        match_d = MATCH_W'(1);
      end
      prev_cls_d = cls;
      if ((match_d == STABLE_C) && (cls != note_q)) begin
        note_d       = cls;
        note_valid_d = 1'b1;
      end
    end

    // Stage 1: measure periods between accepted edges.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (accept) begin
          per_d     = cnt_q;
          per_vld_d = 1'b1;
          cnt_d     = PERIOD_W'(1);
        end else if (cnt_q >= TIMEOUT_C) begin
          state_d      = ST_IDLE;
          note_d       = NOTE_NONE;
          note_valid_d = (note_q != NOTE_NONE);
          match_d      = '0;
          prev_cls_d   = NOTE_NONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset drops any partial period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      per_q        <= '0;
      per_vld_q    <= 1'b0;
      match_q      <= '0;
      prev_cls_q   <= NOTE_NONE;
      note_q       <= NOTE_NONE;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      per_vld_q    <= per_vld_d;
      match_q      <= match_d;
      prev_cls_q   <= prev_cls_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: segment table of waveforms, period-level model, pulse scoreboard.
module tb_note_detector;
  import note_detector_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic [3:0] note;
  logic       note_valid;

  always #5 clk = ~clk;

  note_detector dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .note       (note),
    .note_valid (note_valid)
  );

  typedef struct {
    logic [3:0] note;
    int         lat;
  } exp_t;

  typedef struct {
    int         pa;
    int         pb;
    int         n;
    bit         glitch;
    logic [3:0] exp;
  } seg_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  seg_t       tbl[8];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic [3:0] last_note = 4'hF;

  bit         m_ref;
  int         m_last;
  int         m_match;
  logic [3:0] m_prev;
  logic [3:0] m_note;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ref_cls(input int p);
    int th[13];
    th = '{3934, 3714, 3505, 3308, 3123, 2947, 2782, 2626, 2479, 2340, 2208, 2084, 1967};
    if (p > 3934 || p <= 1967) return 4'hF;
    for (int k = 0; k < 12; k++)
      if (p <= th[k] && p > th[k+1]) return 4'(k);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_ref   = 1'b0;
    m_last  = 0;
    m_match = 0;
    m_prev  = 4'hF;
    m_note  = 4'hF;
  endtask

  task automatic model_timeout();
    exp_t e;
    if (m_note != 4'hF) begin
      e.note = 4'hF;
      e.lat  = 8004;
      sb_q.push_back(e);
    end
    model_reset();
  endtask

  task automatic model_edge(input int c);
    exp_t       e;
    logic [3:0] cls;
    int         d;
    if (!m_ref) begin
      m_ref  = 1'b1;
      m_last = c;
      return;
    end
    d = c - m_last;
`ifdef NOTE_DETECTOR_GLITCH_FILTER_EN
    if (d < 1000) return;
`endif
    m_last = c;
    cls = ref_cls(d);
    if (cls == m_prev) begin
      if (m_match < 3) m_match++;
    end else begin
      m_match = 1;
    end
    m_prev = cls;
    if (m_match == 3 && cls != m_note) begin
      m_note = cls;
      e.note = cls;
      e.lat  = 5;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise();
    sig_in   = 1'b1;
    rise_cyc = cyc;
    model_edge(cyc);
  endtask

  // Each element ends with a rising edge exactly p cycles after the previous one.
  task automatic run_seg(input seg_t s);
    int p;
    for (int i = 0; i < s.n; i++) begin
      p = (i % 2 == 0) ? s.pa : s.pb;
      if (s.glitch) begin
        wait_cyc(p - 400); rise(); wait_cyc(100); sig_in = 1'b0;
        wait_cyc(200);     rise(); wait_cyc(100); sig_in = 1'b0;
      end else begin
        wait_cyc(p - 900); rise(); wait_cyc(900); sig_in = 1'b0;
      end
    end
  endtask

  // Output monitor: every pulse must match the scoreboard head, every change must pulse.
  always @(negedge clk) begin
    if (rst) begin
      last_note = note;
    end else begin
      if (note_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: note=%0h, expected no pulse (cycle %0d)", note, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_note", 32'(note), 32'(mon_e.note));
          check("pulse_latency", 32'(cyc - rise_cyc), 32'(mon_e.lat));
        end
      end
      if (note !== last_note) check("change_has_pulse", 32'(note_valid), 32'd1);
      last_note = note;
    end
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    model_reset();
    tbl[0] = '{2273, 2273, 4, 1'b0, 4'h9};   // 440 Hz from reset
    tbl[1] = '{2273, 2273, 4, 1'b0, 4'h9};   // 440 Hz again after mid-period reset
    tbl[2] = '{3822, 3822, 3, 1'b0, 4'h0};   // switch to C4
    tbl[3] = '{2208, 2208, 3, 1'b0, 4'hA};   // inclusive upper bound of note 10
    tbl[4] = '{2273, 2551, 3, 1'b0, 4'hA};   // alternating classes hold value
    tbl[5] = '{4000, 4000, 2, 1'b0, 4'hF};   // too long
    tbl[6] = '{1900, 1900, 2, 1'b0, 4'hF};   // too short
`ifdef NOTE_DETECTOR_GLITCH_FILTER_EN
    tbl[7] = '{2273, 2273, 4, 1'b1, 4'h9};
`else
    tbl[7] = '{2273, 2273, 4, 1'b1, 4'hF};
`endif

    wait_cyc(3);
    check("reset_note", 32'(note), 32'hF);
    check("reset_valid", 32'(note_valid), 32'd0);
    rst = 1'b0;

    run_seg(tbl[0]);
    check("seg0_note", 32'(note), 32'(tbl[0].exp));

    // Reset in the middle of a measured period.
    wait_cyc(500);
    rst = 1'b1;
    wait_cyc(1);
    check("midrst_note", 32'(note), 32'hF);
    check("midrst_valid", 32'(note_valid), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    model_reset();

    for (int i = 1; i <= 4; i++) begin
      run_seg(tbl[i]);
      check($sformatf("seg%0d_note", i), 32'(note), 32'(tbl[i].exp));
    end

    // Input stops: no change just before the timeout, none after it.
    model_timeout();
    wait_cyc(7000);
    check("pre_timeout_note", 32'(note), 32'(tbl[4].exp));
    wait_cyc(200);
    check("timeout_note", 32'(note), 32'hF);
    check("timeout_state", 32'(dut.state_q), 32'(ST_IDLE));

    for (int i = 5; i <= 6; i++) begin
      run_seg(tbl[i]);
      check($sformatf("seg%0d_note", i), 32'(note), 32'(tbl[i].exp));
    end

    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    model_reset();
    run_seg(tbl[7]);
    check("seg7_note", 32'(note), 32'(tbl[7].exp));

    wait_cyc(20);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
